// File: rtl/plab4_net_term_inject_unit_pkg.sv
// Shared definitions for the terminal injection unit: message field layout
// helpers and security-domain encodings.
package plab4_net_term_inject_unit_pkg;

    typedef enum logic {
        D0 = 1'b0,
        D1 = 1'b1
    } domain_e;

    // Message layout, MSB to LSB: {dest[s], src[s], opaque[o], payload[p]}
    function automatic int msg_nbits(input int p, input int o, input int s);
        return p + o + 2 * s;
    endfunction

    function automatic int payload_lsb(input int p, input int o, input int s);
        return 0;
    endfunction

    function automatic int opaque_lsb(input int p, input int o, input int s);
        return p;
    endfunction

    function automatic int src_lsb(input int p, input int o, input int s);
        return p + o;
    endfunction

    function automatic int dest_lsb(input int p, input int o, input int s);
        return p + o + s;
    endfunction

endpackage

// File: rtl/plab4_net_term_inject_unit_if.sv
// Request and per-domain message handshakes of the injection unit.
// Every channel is val/rdy: a transfer happens on a rising edge where both are high.
interface plab4_net_term_inject_unit_if
    import plab4_net_term_inject_unit_pkg::*;
#(
    parameter int P = 32,
    parameter int O = 3,
    parameter int S = 3,
    parameter int D = 4
);
    localparam int M  = msg_nbits(P, O, S);
    localparam int CW = $clog2(D) + 1;

    logic          req_val;
    logic          req_rdy;
    logic          req_domain;
    logic [S-1:0]  req_dest;
    logic [P-1:0]  req_payload;
    logic          out_val_d0;
    logic          out_rdy_d0;
    logic [M-1:0]  out_msg_d0;
    logic          out_val_d1;
    logic          out_rdy_d1;
    logic [M-1:0]  out_msg_d1;
    logic          bad_dest;
    logic [CW-1:0] count_d0;
    logic [CW-1:0] count_d1;

    modport slave (
        input  req_val, req_domain, req_dest, req_payload, out_rdy_d0, out_rdy_d1,
        output req_rdy, out_val_d0, out_msg_d0, out_val_d1, out_msg_d1,
               bad_dest, count_d0, count_d1
    );

    modport master (
        output req_val, req_domain, req_dest, req_payload, out_rdy_d0, out_rdy_d1,
        input  req_rdy, out_val_d0, out_msg_d0, out_val_d1, out_msg_d1,
               bad_dest, count_d0, count_d1
    );

endinterface

// File: rtl/plab4_net_inject_queue.sv
// Power-of-two depth FIFO with val/rdy on both sides and an occupancy count.
// A full queue refuses enqueue even when it dequeues in the same cycle.
module plab4_net_inject_queue #(
    parameter int W = 41,
    parameter int D = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_enq_val,
    output logic                   o_enq_rdy,
    input  logic [W-1:0]           i_enq_msg,
    output logic                   o_deq_val,
    input  logic                   i_deq_rdy,
    output logic [W-1:0]           o_deq_msg,
    output logic [$clog2(D):0]     o_count
);
    localparam int AW = $clog2(D);
    localparam logic [AW:0] c_full = (AW + 1)'(D);

    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;

    assign w_full    = (r_count == c_full);
    assign w_empty   = (r_count == '0);
    assign w_enq     = i_enq_val && !w_full;
    assign w_deq     = !w_empty && i_deq_rdy;
    assign o_enq_rdy = !w_full;
    assign o_deq_val = !w_empty;
    assign o_count   = r_count;
    // Empty head reads as zero so stale storage never shows after reset.
    assign o_deq_msg = w_empty ? '0 : r_mem[r_head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_enq} - {{AW{1'b0}}, w_deq};
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_tail] <= i_enq_msg;
    end

endmodule

// File: rtl/plab4_net_term_inject_unit.sv
// Packs domain-tagged processor requests into ring messages and queues them
// in two independent per-domain FIFOs; out-of-range dests are dropped.
module plab4_net_term_inject_unit
    import plab4_net_term_inject_unit_pkg::*;
#(
    parameter int p_payload_nbits = 32,
    parameter int p_opaque_nbits  = 3,
    parameter int p_srcdest_nbits = 3,
    parameter int p_router_id     = 0,
    parameter int p_num_routers   = 2,
    parameter int p_queue_depth   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    plab4_net_term_inject_unit_if.slave     io
);
    localparam int P = p_payload_nbits;
    localparam int O = p_opaque_nbits;
    localparam int S = p_srcdest_nbits;
    localparam int c_net_msg_nbits = msg_nbits(P, O, S);
    localparam logic [S-1:0] c_src = S'(p_router_id);
    localparam logic [S:0]   c_num_routers = (S + 1)'(p_num_routers);

    logic [O-1:0]               r_opq0;
    logic [O-1:0]               r_opq1;
    logic                       r_bad;
    logic                       w_is_d1;
    logic                       w_rdy0;
    logic                       w_rdy1;
    logic                       w_fire;
    logic                       w_dest_ok;
    logic                       w_enq0;
    logic                       w_enq1;
    logic [O-1:0]               w_opq;
    logic [c_net_msg_nbits-1:0] w_msg;

    assign w_is_d1     = (domain_e'(io.req_domain) == D1);
    assign io.req_rdy  = w_is_d1 ? w_rdy1 : w_rdy0;
    assign w_fire      = io.req_val && io.req_rdy;
    assign w_dest_ok   = ({1'b0, io.req_dest} < c_num_routers);
    assign w_enq0      = w_fire && w_dest_ok && !w_is_d1;
    assign w_enq1      = w_fire && w_dest_ok && w_is_d1;
    assign w_opq       = w_is_d1 ? r_opq1 : r_opq0;
    assign w_msg       = {io.req_dest, c_src, w_opq, io.req_payload};
    assign io.bad_dest = r_bad;

    // Opaque counters advance only on enqueue, so dropped requests leave no gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_opq0 <= '0;
            r_opq1 <= '0;
            r_bad  <= 1'b0;
        end else begin
            if (w_enq0) r_opq0 <= r_opq0 + 1'b1;
            if (w_enq1) r_opq1 <= r_opq1 + 1'b1;
            r_bad <= w_fire && !w_dest_ok;
        end
    end

    plab4_net_inject_queue #(.W(c_net_msg_nbits), .D(p_queue_depth)) u_queue_d0 (
        .clk       (clk),
        .reset     (reset),
        .i_enq_val (w_enq0),
        .o_enq_rdy (w_rdy0),
        .i_enq_msg (w_msg),
        .o_deq_val (io.out_val_d0),
        .i_deq_rdy (io.out_rdy_d0),
        .o_deq_msg (io.out_msg_d0),
        .o_count   (io.count_d0)
    );

    plab4_net_inject_queue #(.W(c_net_msg_nbits), .D(p_queue_depth)) u_queue_d1 (
        .clk       (clk),
        .reset     (reset),
        .i_enq_val (w_enq1),
        .o_enq_rdy (w_rdy1),
        .i_enq_msg (w_msg),
        .o_deq_val (io.out_val_d1),
        .i_deq_rdy (io.out_rdy_d1),
        .o_deq_msg (io.out_msg_d1),
        .o_count   (io.count_d1)
    );

endmodule

// File: tb/tb_plab4_net_term_inject_unit.sv
// Directed self-checking bench for the terminal injection unit (p=32, o=3, s=3,
// router id 0, two routers, depth 4).
module tb_plab4_net_term_inject_unit;

    localparam int M = 41;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [M-1:0] exp_q[$];
    logic [2:0]   opq0;
    logic [2:0]   opq1;

    plab4_net_term_inject_unit_if #(.P(32), .O(3), .S(3), .D(4)) tif ();

    plab4_net_term_inject_unit #(
        .p_payload_nbits (32),
        .p_opaque_nbits  (3),
        .p_srcdest_nbits (3),
        .p_router_id     (0),
        .p_num_routers   (2),
        .p_queue_depth   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (tif.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [M-1:0] pack(input logic [2:0] dest, input logic [2:0] opq,
                                          input logic [31:0] pay);
        return {dest, 3'd0, opq, pay};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        opq0  = '0;
        opq1  = '0;
        exp_q.delete();
    endtask

    // Presents one request for a single edge; caller knows whether it is accepted.
    task automatic send(input logic dom, input logic [2:0] dest, input logic [31:0] pay);
        tif.req_val     = 1'b1;
        tif.req_domain  = dom;
        tif.req_dest    = dest;
        tif.req_payload = pay;
        step();
        tif.req_val     = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        tif.req_val     = 1'b0;
        tif.req_domain  = 1'b0;
        tif.req_dest    = '0;
        tif.req_payload = '0;
        tif.out_rdy_d0  = 1'b0;
        tif.out_rdy_d1  = 1'b0;
        do_reset();

        check("rst_val_d0",  64'(tif.out_val_d0), 64'd0);
        check("rst_val_d1",  64'(tif.out_val_d1), 64'd0);
        check("rst_msg_d0",  64'(tif.out_msg_d0), 64'd0);
        check("rst_msg_d1",  64'(tif.out_msg_d1), 64'd0);
        check("rst_bad",     64'(tif.bad_dest),   64'd0);
        check("rst_cnt_d0",  64'(tif.count_d0),   64'd0);
        check("rst_cnt_d1",  64'(tif.count_d1),   64'd0);
        check("rst_req_rdy", 64'(tif.req_rdy),    64'd1);

        // single d0 request, visible the cycle after acceptance
        tif.out_rdy_d0 = 1'b1;
        send(1'b0, 3'd1, 32'hDEADBEEF);
        check("first_val_d0", 64'(tif.out_val_d0), 64'd1);
        check("first_msg_d0", 64'(tif.out_msg_d0), 64'({3'd1, 3'd0, 3'd0, 32'hDEADBEEF}));
        check("first_val_d1", 64'(tif.out_val_d1), 64'd0);
        step();
        check("first_drained", 64'(tif.out_val_d0), 64'd0);

        // opaque sequence 0..7 then wrap to 0
        do_reset();
        tif.out_rdy_d0 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(1'b0, 3'd1, 32'h1000 + i);
            check("opq_seq_msg", 64'(tif.out_msg_d0), 64'(pack(3'd1, opq0, 32'h1000 + i)));
            opq0++;
        end
        step();
        check("opq_seq_empty", 64'(tif.out_val_d0), 64'd0);

        // fill d0 under backpressure; d1 unaffected
        do_reset();
        tif.out_rdy_d0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 3'd0, 32'hA0 + i);
            exp_q.push_back(pack(3'd0, opq0, 32'hA0 + i));
            opq0++;
        end
        tif.req_domain = 1'b0;
        #1;
        check("full_cnt_d0", 64'(tif.count_d0), 64'd4);
        check("full_rdy_d0", 64'(tif.req_rdy),  64'd0);
        tif.req_domain = 1'b1;
        #1;
        check("full_rdy_d1", 64'(tif.req_rdy),  64'd1);
        tif.out_rdy_d1 = 1'b1;
        send(1'b1, 3'd0, 32'h5555_AAAA);
        check("d1_val", 64'(tif.out_val_d1), 64'd1);
        check("d1_msg", 64'(tif.out_msg_d1), 64'(pack(3'd0, opq1, 32'h5555_AAAA)));
        opq1++;
        check("d0_hold", 64'(tif.out_msg_d0), 64'(exp_q[0]));

        // full queue refuses enqueue even while dequeuing
        tif.out_rdy_d0 = 1'b1;
        send(1'b0, 3'd1, 32'hBAD0_0000);
        tif.out_rdy_d0 = 1'b0;
        void'(exp_q.pop_front());
        check("full_no_pass_cnt",  64'(tif.count_d0),   64'd3);
        check("full_no_pass_head", 64'(tif.out_msg_d0), 64'(exp_q[0]));
        tif.out_rdy_d0 = 1'b1;
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            check("drain_val", 64'(tif.out_val_d0), 64'd1);
            check("drain_msg", 64'(tif.out_msg_d0), 64'(exp_q.pop_front()));
            step();
        end
        check("drain_done_q",   64'(exp_q.size()),   64'd0);
        check("drain_done_val", 64'(tif.out_val_d0), 64'd0);

        // out-of-range dest: dropped, one-cycle bad_dest, counter unchanged
        send(1'b0, 3'd5, 32'h0BAD);
        check("bad_pulse",   64'(tif.bad_dest),   64'd1);
        check("bad_no_enq",  64'(tif.out_val_d0), 64'd0);
        check("bad_cnt",     64'(tif.count_d0),   64'd0);
        step();
        check("bad_cleared", 64'(tif.bad_dest),   64'd0);
        send(1'b0, 3'd1, 32'h600D);
        check("bad_next_opq", 64'(tif.out_msg_d0), 64'(pack(3'd1, opq0, 32'h600D)));
        opq0++;
        step();

        // simultaneous enqueue/dequeue with two entries held
        tif.out_rdy_d0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send(1'b0, 3'd1, 32'hC0 + i);
            exp_q.push_back(pack(3'd1, opq0, 32'hC0 + i));
            opq0++;
        end
        check("two_cnt", 64'(tif.count_d0), 64'd2);
        tif.out_rdy_d0 = 1'b1;
        send(1'b0, 3'd0, 32'hC2);
        tif.out_rdy_d0 = 1'b0;
        exp_q.push_back(pack(3'd0, opq0, 32'hC2));
        opq0++;
        void'(exp_q.pop_front());
        check("simul_cnt",  64'(tif.count_d0),   64'd2);
        check("simul_head", 64'(tif.out_msg_d0), 64'(exp_q[0]));

        // asynchronous reset mid-burst
        tif.out_rdy_d1 = 1'b0;
        send(1'b1, 3'd1, 32'hD1);
        tif.req_val     = 1'b1;
        tif.req_domain  = 1'b0;
        tif.req_dest    = 3'd1;
        tif.req_payload = 32'hD0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_val_d0", 64'(tif.out_val_d0), 64'd0);
        check("arst_val_d1", 64'(tif.out_val_d1), 64'd0);
        check("arst_cnt_d0", 64'(tif.count_d0),   64'd0);
        check("arst_cnt_d1", 64'(tif.count_d1),   64'd0);
        check("arst_msg_d0", 64'(tif.out_msg_d0), 64'd0);
        tif.req_val = 1'b0;
        step();
        reset = 1'b1;
        opq0  = '0;
        opq1  = '0;
        exp_q.delete();
        tif.out_rdy_d0 = 1'b1;
        tif.out_rdy_d1 = 1'b1;
        send(1'b0, 3'd1, 32'hE0);
        check("post_rst_d0", 64'(tif.out_msg_d0), 64'(pack(3'd1, 3'd0, 32'hE0)));
        send(1'b1, 3'd0, 32'hE1);
        check("post_rst_d1", 64'(tif.out_msg_d1), 64'(pack(3'd0, 3'd0, 32'hE1)));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
